// File: rtl/tally_arbiter_if.sv
// ---------------------------------------------------------------------------
// tally_arbiter_if
// Bundles the booth, clear, query and tally-RAM signals of tally_arbiter.
//   slave  : arbiter side (booth/clear/query/RAM-read in, acks/RAM-write out)
//   master : environment side (booth encoders, clear button, readout, RAM)
// Signals:
//   vote_req/vote_cand   booth vote pulses, 4-bit candidate per booth
//   vote_ack/vote_drop   per-booth commit / reject pulses
//   clear_req/clear_done zero-all-words command and completion pulse
//   query_*              level-held read request and registered result
//   mem_*                tally RAM port (combinational read, sync write)
//   busy, sat            controller activity and sticky saturation flag
// ---------------------------------------------------------------------------
interface tally_arbiter_if #(
  parameter int NUM_BOOTHS = 4,
  parameter int CNT_W      = 10
);
  logic [NUM_BOOTHS-1:0]   vote_req;
  logic [4*NUM_BOOTHS-1:0] vote_cand;
  logic [NUM_BOOTHS-1:0]   vote_ack;
  logic [NUM_BOOTHS-1:0]   vote_drop;
  logic                    clear_req;
  logic                    clear_done;
  logic                    query_valid;
  logic [4:0]              query_addr;
  logic [CNT_W-1:0]        query_data;
  logic                    query_done;
  logic [4:0]              mem_addr;
  logic                    mem_we;
  logic [CNT_W-1:0]        mem_wdata;
  logic [CNT_W-1:0]        mem_rdata;
  logic                    busy;
  logic                    sat;

  modport slave (
    input  vote_req, vote_cand, clear_req, query_valid, query_addr, mem_rdata,
    output vote_ack, vote_drop, clear_done, query_data, query_done,
           mem_addr, mem_we, mem_wdata, busy, sat
  );

  modport master (
    output vote_req, vote_cand, clear_req, query_valid, query_addr, mem_rdata,
    input  vote_ack, vote_drop, clear_done, query_data, query_done,
           mem_addr, mem_we, mem_wdata, busy, sat
  );
endinterface

// File: rtl/tally_arbiter.sv
// ---------------------------------------------------------------------------
// tally_arbiter
// Shares one 32 x CNT_W tally RAM between NUM_BOOTHS vote booths, a clear
// command and a count readout. Each accepted vote is a read-modify-write of
// the candidate word {0,cand} followed by the total word at TOTAL_ADDR.
// Ports:
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     tally_arbiter_if.slave (booth, clear, query and RAM signals)
// ---------------------------------------------------------------------------
module tally_arbiter #(
  parameter int NUM_BOOTHS = 4,
  parameter int CNT_W      = 10,
  parameter int TOTAL_ADDR = 16
) (
  input logic            clk,
  input logic            resetn,
  tally_arbiter_if.slave bus
);

  localparam int IW = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
  localparam logic [4:0] TOT_ADDR = 5'(TOTAL_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CAND,
    S_TOTAL,
    S_QUERY
  } state_t;

  state_t                      state_q, state_d;
  logic [NUM_BOOTHS-1:0]       pending_q, pending_d;
  logic [NUM_BOOTHS-1:0][3:0]  cand_q, cand_d;
  logic                        clear_pend_q, clear_pend_d;
  logic [IW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [4:0]                  clr_ptr_q, clr_ptr_d;
  logic [IW-1:0]               win_q, win_d;
  logic [3:0]                  win_cand_q, win_cand_d;
  logic [4:0]                  qaddr_q, qaddr_d;
  logic [CNT_W-1:0]            qdata_q, qdata_d;
  logic                        qdone_q, qdone_d;
  logic                        cdone_q, cdone_d;
  logic [NUM_BOOTHS-1:0]       ack_q, ack_d;
  logic [NUM_BOOTHS-1:0]       drop_q, drop_d;
  logic                        sat_q, sat_d;

  logic [NUM_BOOTHS-1:0]       grant_clr;
  logic                        rr_found;
  logic [IW-1:0]               rr_win;
  logic [IW-1:0]               rr_idx;
  logic [CNT_W:0]              inc_res;
  logic [4:0]                  mem_addr_d;
  logic                        mem_we_d;
  logic [CNT_W-1:0]            mem_wdata_d;

  // Saturating increment; MSB of the result flags that x was already at max.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] x);
    if (x == {CNT_W{1'b1}}) begin
      return {1'b1, x};
    end
    return {1'b0, x + 1'b1};
  endfunction

  // Round-robin search: first pending booth strictly after the last winner.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_BOOTHS; k++) begin
      rr_idx = IW'((int'(rr_ptr_q) + k) % NUM_BOOTHS);
      if (!rr_found && pending_q[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end
  end

  // Per-booth intake. A grant clearing pending in the same cycle as a new
  // request lets the new request in (set wins), so no drop is reported.
  generate
    for (genvar gi = 0; gi < NUM_BOOTHS; gi++) begin : g_intake
      logic still_pend;
      assign still_pend    = pending_q[gi] & ~grant_clr[gi];
      assign pending_d[gi] = still_pend | bus.vote_req[gi];
      assign drop_d[gi]    = bus.vote_req[gi] & still_pend;
      assign cand_d[gi]    = (bus.vote_req[gi] && !still_pend)
                             ? bus.vote_cand[4*gi +: 4] : cand_q[gi];
    end
  endgenerate

  // Controller next-state and RAM port decode.
  always_comb begin
    state_d      = state_q;
    clear_pend_d = clear_pend_q | bus.clear_req;
    rr_ptr_d     = rr_ptr_q;
    clr_ptr_d    = clr_ptr_q;
    win_d        = win_q;
    win_cand_d   = win_cand_q;
    qaddr_d      = qaddr_q;
    qdata_d      = qdata_q;
    qdone_d      = 1'b0;
    cdone_d      = 1'b0;
    ack_d        = '0;
    sat_d        = sat_q;
    grant_clr    = '0;
    mem_addr_d   = '0;
    mem_we_d     = 1'b0;
    mem_wdata_d  = '0;
    inc_res      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (clear_pend_q) begin
          state_d      = S_CLEAR;
          clr_ptr_d    = '0;
          clear_pend_d = bus.clear_req;
        end else if (rr_found) begin
          state_d           = S_CAND;
          win_d             = rr_win;
          // Candidate is copied now: the booth slot may be refilled by a new
          // vote while this one is still being written.
          win_cand_d        = cand_q[rr_win];
          grant_clr[rr_win] = 1'b1;
          rr_ptr_d          = rr_win;
        end else if (bus.query_valid) begin
          state_d = S_QUERY;
          qaddr_d = bus.query_addr;
        end
      end
      S_CLEAR: begin
        mem_addr_d = clr_ptr_q;
        mem_we_d   = 1'b1;
        clr_ptr_d  = clr_ptr_q + 5'd1;
        if (clr_ptr_q == 5'd31) begin
          state_d = S_IDLE;
          cdone_d = 1'b1;
          sat_d   = 1'b0;
        end
      end
      S_CAND: begin
        mem_addr_d  = {1'b0, win_cand_q};
        mem_we_d    = 1'b1;
        inc_res     = sat_inc(bus.mem_rdata);
        mem_wdata_d = inc_res[CNT_W-1:0];
        if (inc_res[CNT_W]) sat_d = 1'b1;
        state_d     = S_TOTAL;
      end
      S_TOTAL: begin
        mem_addr_d    = TOT_ADDR;
        mem_we_d      = 1'b1;
        inc_res       = sat_inc(bus.mem_rdata);
        mem_wdata_d   = inc_res[CNT_W-1:0];
        if (inc_res[CNT_W]) sat_d = 1'b1;
        ack_d[win_q]  = 1'b1;
        state_d       = S_IDLE;
      end
      S_QUERY: begin
        mem_addr_d = qaddr_q;
        qdata_d    = bus.mem_rdata;
        qdone_d    = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      cand_q       <= '0;
      clear_pend_q <= 1'b0;
      rr_ptr_q     <= '0;
      clr_ptr_q    <= '0;
      win_q        <= '0;
      win_cand_q   <= '0;
      qaddr_q      <= '0;
      qdata_q      <= '0;
      qdone_q      <= 1'b0;
      cdone_q      <= 1'b0;
      ack_q        <= '0;
      drop_q       <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      cand_q       <= cand_d;
      clear_pend_q <= clear_pend_d;
      rr_ptr_q     <= rr_ptr_d;
      clr_ptr_q    <= clr_ptr_d;
      win_q        <= win_d;
      win_cand_q   <= win_cand_d;
      qaddr_q      <= qaddr_d;
      qdata_q      <= qdata_d;
      qdone_q      <= qdone_d;
      cdone_q      <= cdone_d;
      ack_q        <= ack_d;
      drop_q       <= drop_d;
      sat_q        <= sat_d;
    end
  end

  assign bus.vote_ack   = ack_q;
  assign bus.vote_drop  = drop_q;
  assign bus.clear_done = cdone_q;
  assign bus.query_data = qdata_q;
  assign bus.query_done = qdone_q;
  assign bus.mem_addr   = mem_addr_d;
  assign bus.mem_we     = mem_we_d;
  assign bus.mem_wdata  = mem_wdata_d;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.sat        = sat_q;

endmodule

// File: tb/tb_tally_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tally_arbiter
// Directed scenarios plus a randomized vote phase for tally_arbiter. The
// bench owns the tally RAM, keeps an expected-count array updated per
// committed vote, and derives commit order from the round-robin rule.
// ---------------------------------------------------------------------------
module tb_tally_arbiter;
  localparam int NB    = 4;
  localparam int CW    = 10;
  localparam int BOUND = 3*NB + 32 + 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  tally_arbiter_if #(.NUM_BOOTHS(NB), .CNT_W(CW)) bus();

  tally_arbiter #(.NUM_BOOTHS(NB), .CNT_W(CW), .TOTAL_ADDR(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Tally RAM: combinational read, synchronous write, plus a bench preload port.
  logic [CW-1:0] ram [32];
  logic          ram_wipe;
  logic          pre_we;
  logic [4:0]    pre_addr;
  logic [CW-1:0] pre_data;

  always @(posedge clk) begin
    if (ram_wipe) begin
      for (int a = 0; a < 32; a++) ram[a] <= '0;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end else if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end
  end
  assign bus.mem_rdata = ram[bus.mem_addr];

  int checks   = 0;
  int failures = 0;

  int exp_ram [32];
  bit exp_sat;
  int rr_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic void model_vote(input int c);
    if (exp_ram[c] == 1023) exp_sat = 1'b1; else exp_ram[c] = exp_ram[c] + 1;
    if (exp_ram[16] == 1023) exp_sat = 1'b1; else exp_ram[16] = exp_ram[16] + 1;
  endfunction

  function automatic void model_clear();
    for (int a = 0; a < 32; a++) exp_ram[a] = 0;
    exp_sat = 1'b0;
  endfunction

  task automatic query_check(input int addr, input string tag);
    bit got;
    got = 1'b0;
    bus.query_valid = 1'b1;
    bus.query_addr  = 5'(addr);
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.query_done) begin
        got = 1'b1;
        break;
      end
    end
    bus.query_valid = 1'b0;
    check({tag, "_done"}, 32'(got), 32'd1);
    check(tag, 32'(bus.query_data), 32'(exp_ram[addr]));
  endtask

  task automatic ram_compare(input string tag);
    for (int a = 0; a < 32; a++) check(tag, 32'(ram[a]), 32'(exp_ram[a]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int            order [$];
  logic [NB-1:0] mask;
  logic [NB-1:0] exp_vec;
  int            last, idx, j, lat, cyc;
  bit            got;
  bit            outstanding [NB];
  int            req_cyc [NB];
  int            cand_of [NB];
  logic [4*NB-1:0] vc;
  logic [NB-1:0] rq;

  initial begin
    resetn          = 1'b0;
    ram_wipe        = 1'b1;
    pre_we          = 1'b0;
    pre_addr        = '0;
    pre_data        = '0;
    bus.vote_req    = '0;
    bus.vote_cand   = '0;
    bus.clear_req   = 1'b0;
    bus.query_valid = 1'b0;
    bus.query_addr  = '0;
    model_clear();
    rr_model = 0;
    tick(); tick();
    // Reset state
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ack", 32'(bus.vote_ack), 0);
    check("rst_drop", 32'(bus.vote_drop), 0);
    check("rst_qdata", 32'(bus.query_data), 0);
    check("rst_qdone", 32'(bus.query_done), 0);
    check("rst_cdone", 32'(bus.clear_done), 0);
    check("rst_sat", 32'(bus.sat), 0);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_wdata", 32'(bus.mem_wdata), 0);
    resetn   = 1'b1;
    ram_wipe = 1'b0;
    tick();

    // 1: single vote, ack exactly 4 cycles after request
    bus.vote_req  = 4'b0001;
    bus.vote_cand = 16'h0003;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) bus.vote_req = '0;
      check($sformatf("t1_ack_c%0d", k), 32'(bus.vote_ack), (k == 4) ? 32'd1 : 32'd0);
      if (k == 2) check("t1_busy_cand", 32'(bus.busy), 1);
      if (k == 3) check("t1_total_addr", 32'(bus.mem_addr), 16);
    end
    model_vote(3);
    rr_model = 0;
    query_check(3, "t1_q3");
    query_check(16, "t1_q16");

    // 2: all four booths in one cycle, round-robin commit order
    bus.vote_req  = 4'hF;
    bus.vote_cand = 16'h5121;
    order.delete();
    mask = 4'hF;
    last = rr_model;
    while (mask != 0) begin
      for (int s = 1; s <= NB; s++) begin
        idx = (last + s) % NB;
        if (mask[idx]) begin
          order.push_back(idx);
          mask[idx] = 1'b0;
          last = idx;
          break;
        end
      end
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) bus.vote_req = '0;
      exp_vec = '0;
      if (k >= 4 && (k - 4) % 3 == 0 && (k - 4) / 3 < NB) begin
        j = (k - 4) / 3;
        exp_vec[order[j]] = 1'b1;
      end
      check($sformatf("t2_ack_c%0d", k), 32'(bus.vote_ack), 32'(exp_vec));
    end
    rr_model = last;
    model_vote(1); model_vote(2); model_vote(1); model_vote(5);
    query_check(1, "t2_q1");
    query_check(2, "t2_q2");
    query_check(5, "t2_q5");
    query_check(16, "t2_q16");

    // 3: booth2 re-pulses while still pending -> one drop, first vote kept
    bus.vote_req  = 4'b0001;
    bus.vote_cand = 16'h0004;
    tick();
    bus.vote_req  = 4'b0100;
    bus.vote_cand = 16'h0900;
    tick();
    check("t3_nodrop", 32'(bus.vote_drop), 0);
    bus.vote_cand = 16'h0a00;
    tick();
    bus.vote_req = '0;
    check("t3_drop", 32'(bus.vote_drop), 32'b0100);
    for (int k = 4; k <= 9; k++) begin
      tick();
      check($sformatf("t3_ack_c%0d", k), 32'(bus.vote_ack),
            (k == 4) ? 32'b0001 : (k == 7) ? 32'b0100 : 32'd0);
      if (k > 3) check($sformatf("t3_drop_c%0d", k), 32'(bus.vote_drop), 0);
    end
    model_vote(4); model_vote(9);
    query_check(9, "t3_q9");
    query_check(10, "t3_q10");
    query_check(16, "t3_q16");

    // 4: saturation of a preloaded word, then clear resets sat
    pre_we   = 1'b1;
    pre_addr = 5'd7;
    pre_data = 10'd1023;
    tick();
    pre_we = 1'b0;
    exp_ram[7] = 1023;
    bus.vote_req  = 4'b0010;
    bus.vote_cand = 16'h0070;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) bus.vote_req = '0;
      if (k == 4) check("t4_ack", 32'(bus.vote_ack), 32'b0010);
    end
    model_vote(7);
    check("t4_sat", 32'(bus.sat), 32'(exp_sat));
    query_check(7, "t4_q7");
    query_check(16, "t4_q16");
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus.clear_done) begin got = 1'b1; break; end
    end
    check("t4_clear_done", 32'(got), 1);
    model_clear();
    check("t4_sat_cleared", 32'(bus.sat), 32'(exp_sat));
    ram_compare("t4_ram");

    // 5: clear with a vote queued during it
    bus.clear_req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) bus.clear_req = 1'b0;
      if (k == 5) begin bus.vote_req = 4'b0010; bus.vote_cand = 16'h00c0; end
      if (k == 6) bus.vote_req = '0;
      if (k == 2) check("t5_busy_clear", 32'(bus.busy), 1);
      check($sformatf("t5_cdone_c%0d", k), 32'(bus.clear_done), (k == 34) ? 32'd1 : 32'd0);
      check($sformatf("t5_ack_c%0d", k), 32'(bus.vote_ack), (k == 37) ? 32'b0010 : 32'd0);
    end
    model_clear();
    model_vote(12);
    ram_compare("t5_ram");

    // 6: asynchronous reset during TOTAL
    bus.vote_req  = 4'b1000;
    bus.vote_cand = 16'h6000;
    tick();
    bus.vote_req = '0;
    tick();
    check("t6_cand_we", 32'(bus.mem_we), 1);
    check("t6_cand_addr", 32'(bus.mem_addr), 6);
    tick();
    check("t6_total_addr", 32'(bus.mem_addr), 16);
    resetn = 1'b0;
    #1;
    check("t6_rst_busy", 32'(bus.busy), 0);
    check("t6_rst_we", 32'(bus.mem_we), 0);
    check("t6_rst_addr", 32'(bus.mem_addr), 0);
    check("t6_rst_wdata", 32'(bus.mem_wdata), 0);
    check("t6_rst_ack", 32'(bus.vote_ack), 0);
    exp_ram[6] = exp_ram[6] + 1;
    tick(); tick();
    resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t6_no_ack", 32'(bus.vote_ack), 0);
      check("t6_idle", 32'(bus.busy), 0);
    end
    ram_compare("t6_ram");

    // Randomized votes: every booth request commits exactly once, in bound
    for (int b = 0; b < NB; b++) outstanding[b] = 1'b0;
    cyc = 0;
    for (int c = 0; c < 500; c++) begin
      tick();
      cyc++;
      for (int b = 0; b < NB; b++) begin
        if (bus.vote_ack[b]) begin
          check("rnd_ack_expected", 32'(outstanding[b]), 1);
          lat = cyc - req_cyc[b];
          check("rnd_latency_ok", 32'(lat <= BOUND), 1);
          if (outstanding[b]) model_vote(cand_of[b]);
          outstanding[b] = 1'b0;
        end
      end
      if (bus.vote_drop != '0) check("rnd_drop", 32'(bus.vote_drop), 0);
      rq = '0;
      vc = bus.vote_cand;
      if (c < 450) begin
        for (int b = 0; b < NB; b++) begin
          if (!outstanding[b] && $urandom_range(3) == 0) begin
            rq[b]          = 1'b1;
            cand_of[b]     = int'($urandom_range(15));
            vc[4*b +: 4]   = 4'(cand_of[b]);
            outstanding[b] = 1'b1;
            req_cyc[b]     = cyc;
          end
        end
      end
      bus.vote_req  = rq;
      bus.vote_cand = vc;
    end
    got = 1'b0;
    for (int b = 0; b < NB; b++) if (outstanding[b]) got = 1'b1;
    check("rnd_drained", 32'(got), 0);
    ram_compare("rnd_ram");
    check("rnd_sat", 32'(bus.sat), 32'(exp_sat));
    query_check(16, "rnd_q16");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
